// File: rtl/stream_pkg.sv
// Shared stream types and helpers for the narrow-to-wide packing path.
package stream_pkg;

  typedef enum logic [0:0] {ST_FILL, ST_EMIT} PackState_t;

  function automatic int lanes_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs RATIO consecutive narrow words into one wide beat, lane 0 first.
// A word marked last flushes a partially filled beat early.
module word_packer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IN_valid,
  input  logic [IN_WIDTH-1:0]           IN_data,
  input  logic                          IN_last,
  output logic                          OUT_ready,
  input  logic                          IN_ready,
  output logic                          OUT_valid,
  output logic [IN_WIDTH*RATIO-1:0]     OUT_data,
  output logic [lanes_w(RATIO)-1:0]     OUT_count,
  output logic                          OUT_last
);

  localparam int              CntW       = lanes_w(RATIO);
  localparam logic [CntW-1:0] FullCnt    = CntW'(RATIO);
  localparam logic [CntW-1:0] OneCnt     = CntW'(1);
  localparam bit              SingleLane = (RATIO == 1);

  PackState_t                state, stateNext;
  logic [IN_WIDTH*RATIO-1:0] buffer, bufferNext;
  logic [CntW-1:0]           cnt, cntNext, cntInc;
  logic                      lastFlag, lastNext;
  logic                      acc;
  logic [RATIO-1:0]          laneEn;

  // IN_ready reaches OUT_ready combinationally; IN_valid never does.
  assign OUT_ready = (state == ST_FILL) || ((state == ST_EMIT) && IN_ready);
  assign acc       = IN_valid && OUT_ready;
  assign cntInc    = cnt + OneCnt;

  assign OUT_valid = (state == ST_EMIT);
  assign OUT_data  = buffer;
  assign OUT_count = cnt;
  assign OUT_last  = lastFlag;

  always_comb begin
    laneEn = '0;
    for (int k = 0; k < RATIO; k++) begin
      laneEn[k] = (cnt == CntW'(k));
    end
  end

  always_comb begin
    stateNext  = state;
    bufferNext = buffer;
    cntNext    = cnt;
    lastNext   = lastFlag;
    unique case (state)
      ST_FILL: begin
        if (acc) begin
          for (int k = 0; k < RATIO; k++) begin
            if (laneEn[k]) bufferNext[k*IN_WIDTH +: IN_WIDTH] = IN_data;
          end
          cntNext = cntInc;
          if ((cntInc == FullCnt) || IN_last) begin
            stateNext = ST_EMIT;
            lastNext  = IN_last;
          end
        end
      end
      ST_EMIT: begin
        if (IN_ready) begin
          // Retiring beat: untouched lanes must read zero in the next beat.
          bufferNext = '0;
          cntNext    = '0;
          lastNext   = 1'b0;
          stateNext  = ST_FILL;
          if (acc) begin
            bufferNext[IN_WIDTH-1:0] = IN_data;
            cntNext                  = OneCnt;
            if (SingleLane || IN_last) begin
              stateNext = ST_EMIT;
              lastNext  = IN_last;
            end
          end
        end
      end
      default: stateNext = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      buffer   <= '0;
      cnt      <= '0;
      lastFlag <= 1'b0;
    end else begin
      state    <= stateNext;
      buffer   <= bufferNext;
      cnt      <= cntNext;
      lastFlag <= lastNext;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: RATIO=4 and RATIO=1 builds driven by the same stream.
module tb_word_packer;
  import stream_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inValid = 1'b0;
  logic [W-1:0] inData = '0;
  logic inLast = 1'b0;
  logic inReady = 1'b1;

  logic rdy4, vld4, last4;
  logic [4*W-1:0] data4;
  logic [2:0] cnt4;
  logic rdy1, vld1, last1;
  logic [W-1:0] data1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;
  int retired4 = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  word_packer #(.IN_WIDTH(W), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .IN_valid(inValid), .IN_data(inData), .IN_last(inLast),
    .OUT_ready(rdy4), .IN_ready(inReady), .OUT_valid(vld4), .OUT_data(data4),
    .OUT_count(cnt4), .OUT_last(last4)
  );

  word_packer #(.IN_WIDTH(W), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .IN_valid(inValid), .IN_data(inData), .IN_last(inLast),
    .OUT_ready(rdy1), .IN_ready(inReady), .OUT_valid(vld1), .OUT_data(data1),
    .OUT_count(cnt1), .OUT_last(last1)
  );

  // Model per build: a gather list of words and an outstanding beat.
  logic [W-1:0] gw [2][4];
  logic [W-1:0] bw [2][4];
  int gn [2];
  int bn [2];
  bit bv [2];
  bit bl [2];
  logic [W-1:0] sbq [$];

  function automatic int ratioOf(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  initial begin
    bit rdyM;
    for (int m = 0; m < 2; m++) begin
      gn[m] = 0; bn[m] = 0; bv[m] = 1'b0; bl[m] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          gn[m] = 0; bn[m] = 0; bv[m] = 1'b0; bl[m] = 1'b0;
        end
        sbq.delete();
      end else begin
        for (int m = 0; m < 2; m++) begin
          rdyM = !bv[m] || inReady;
          if (bv[m] && inReady) begin
            bv[m] = 1'b0;
            bl[m] = 1'b0;
          end
          if (inValid && rdyM) begin
            gw[m][gn[m]] = inData;
            gn[m]++;
            if (m == 0) sbq.push_back(inData);
            if (gn[m] == ratioOf(m) || inLast) begin
              bw[m] = gw[m];
              bn[m] = gn[m];
              bv[m] = 1'b1;
              bl[m] = inLast;
              gn[m] = 0;
            end
          end
        end
      end
    end
  end

  function automatic logic [4*W-1:0] expData(input int m);
    logic [4*W-1:0] d;
    int n;
    d = '0;
    n = bv[m] ? bn[m] : gn[m];
    for (int k = 0; k < n; k++) d[k*W +: W] = bv[m] ? bw[m][k] : gw[m][k];
    return d;
  endfunction

  task automatic chk(input string name, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4*W-1:0] e;
    logic [W-1:0] w;
    if (started) begin
      e = expData(0);
      chk("m4.valid", vld4, bv[0]);
      chk("m4.data", data4, e);
      chk("m4.count", cnt4, bv[0] ? bn[0] : gn[0]);
      chk("m4.last", last4, bv[0] && bl[0]);
      chk("m4.ready", rdy4, !bv[0] || inReady);
      e = expData(1);
      chk("m1.valid", vld1, bv[1]);
      chk("m1.data", data1, e[W-1:0]);
      chk("m1.count", cnt1, bv[1] ? bn[1] : gn[1]);
      chk("m1.last", last1, bv[1] && bl[1]);
      chk("m1.ready", rdy1, !bv[1] || inReady);
      if (vld4 && inReady) begin
        retired4++;
        for (int k = 0; k < int'(cnt4); k++) begin
          if (k >= 4) break;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb.empty lane=%0d got=%0h exp=none", k, data4[k*W +: W]);
          end else begin
            w = sbq.pop_front();
            chk("sb.word", data4[k*W +: W], w);
          end
        end
      end
    end
  end

  task automatic put(input bit v, input logic [W-1:0] d, input bit l, input bit r);
    inValid = v;
    inData  = d;
    inLast  = l;
    inReady = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4*W-1:0] x;
    int r0;
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.valid", vld4, 0);
    chk("rst.count", cnt4, 0);
    chk("rst.ready", rdy4, 1);

    put(1, 32'h11, 0, 1);
    put(1, 32'h22, 0, 1);
    put(1, 32'h33, 0, 1);
    put(1, 32'h44, 0, 1);
    chk("full.valid", vld4, 1);
    chk("full.data", data4, 128'h00000044_00000033_00000022_00000011);
    chk("full.count", cnt4, 4);
    chk("full.last", last4, 0);
    put(0, 0, 0, 1);

    put(1, 32'hA, 0, 1);
    put(1, 32'hB, 1, 1);
    chk("part.valid", vld4, 1);
    chk("part.data", data4, 128'h0000000B_0000000A);
    chk("part.count", cnt4, 2);
    chk("part.last", last4, 1);
    put(0, 0, 0, 1);

    put(1, 32'h1, 0, 1);
    put(1, 32'h2, 0, 1);
    put(1, 32'h3, 0, 1);
    put(1, 32'h4, 0, 1);
    for (int i = 0; i < 5; i++) begin
      put(1, 32'h55, 0, 0);
      chk("bp.ready", rdy4, 0);
      chk("bp.valid", vld4, 1);
      chk("bp.data", data4, 128'h00000004_00000003_00000002_00000001);
      chk("bp.count", cnt4, 4);
    end
    put(1, 32'h55, 0, 1);
    chk("bp.rel.valid", vld4, 0);
    chk("bp.rel.data", data4, 128'h55);
    chk("bp.rel.count", cnt4, 1);

    put(1, 32'h66, 0, 1);
    chk("pre.count", cnt4, 2);
    inValid = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.valid", vld4, 0);
    chk("mid.count", cnt4, 0);
    chk("mid.data", data4, 0);
    chk("mid.ready", rdy4, 1);

    r0 = retired4;
    for (int i = 0; i < 16; i++) begin
      put(1, 32'h100 + i, 0, 1);
      chk("sus.valid", vld4, (i % 4) == 3);
      if ((i % 4) == 3) begin
        for (int k = 0; k < 4; k++) x[k*W +: W] = 32'h100 + (i - 3 + k);
        chk("sus.data", data4, x);
      end
      chk("r1.valid", vld1, 1);
      chk("r1.data", data1, 32'h100 + i);
      chk("r1.count", cnt1, 1);
    end
    put(0, 0, 0, 1);
    put(0, 0, 0, 1);
    chk("sus.beats", retired4 - r0, 4);
    chk("sus.drained", sbq.size(), 0);

    put(0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Downstream consumer of the FIFO stage. Takes narrow words from the FIFO's valid/ready output and packs RATIO consecutive words into one wide beat for a wide datapath.
- Supports early flush on a last marker, so short packets emit partially filled beats.
- Sustains one narrow word per cycle when the wide side is always ready.

Parameters:
IN_WIDTH, 32, width of one narrow input word
RATIO, 4, narrow words per wide output beat (>= 1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
IN_valid  input  1  narrow word valid (from FIFO OUT_valid)
IN_data  input  IN_WIDTH  narrow word (from FIFO OUT_data)
IN_last  input  1  accepted word ends the packet; flush partial beat
OUT_ready  output  1  ready to FIFO (drives FIFO IN_ready)
IN_ready  input  1  wide sink ready
OUT_valid  output  1  wide beat valid
OUT_data  output  IN_WIDTH*RATIO  wide beat; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
OUT_count  output  $clog2(RATIO+1)  number of filled lanes in the beat (1..RATIO when valid)
OUT_last  output  1  beat closes a packet

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State registers:
  - state: ST_FILL or ST_EMIT
  - buffer: IN_WIDTH*RATIO bits
  - cnt: $clog2(RATIO+1) bits
  - lastFlag: 1 bit
- Reset: state=ST_FILL, cnt=0, buffer=0, lastFlag=0. So OUT_valid=0, OUT_data=0, OUT_count=0, OUT_last=0, and OUT_ready=1 from the first cycle after reset.
- Combinational outputs:
  - OUT_ready = (state==ST_FILL) || (state==ST_EMIT && IN_ready)
  - OUT_valid = (state==ST_EMIT); OUT_data=buffer; OUT_count=cnt; OUT_last=lastFlag
- Accept: acc = IN_valid && OUT_ready. The word is written to lane cnt (lane 0 first, little-endian packing).
- ST_FILL on acc:
  - Write the lane, cnt+1.
  - If cnt+1==RATIO or IN_last: go to ST_EMIT, lastFlag=IN_last.
- ST_EMIT with IN_ready=0:
  - Hold state. buffer, cnt and lastFlag stay bit-stable.
  - OUT_ready=0, so no accept.
- ST_EMIT with IN_ready=1 and no acc: buffer=0, cnt=0, lastFlag=0, go to ST_FILL.
- ST_EMIT with IN_ready=1 and acc (pass-through):
  - Beat retires. buffer becomes the new word in lane 0, other lanes 0; cnt=1.
  - If RATIO==1 or IN_last: stay ST_EMIT, lastFlag=IN_last.
  - Else: go to ST_FILL, lastFlag=0.
- Lanes not written since the last emit are always 0. A partial beat never carries stale data.
- Latency: the beat is valid the cycle after the accept that completes it (one register stage). No bubble between beats when IN_ready is held high.
- No combinational path IN_valid->OUT_ready. IN_ready->OUT_ready is combinational (documented; the FIFO tolerates it).
- IN_last is sampled only on accepted words, so cnt>=1 whenever ST_EMIT is entered.
- Reset mid-packet: the partial beat and a pending beat are discarded with no emission. The FIFO is unaffected.
- cnt never exceeds RATIO. No wrap.

Decomposition:
- Shared package stream_pkg holds:
  - typedef enum logic[0:0] {ST_FILL, ST_EMIT} PackState_t
  - function lanes_w(RATIO) returning $clog2(RATIO+1)
- No sub-module. Lane write-enable decode is inline (RATIO-wide one-hot from cnt).

Test Plan:
- Reset: rst pulsed mid-run with cnt=2 -> next cycle OUT_valid=0, OUT_count=0, OUT_data=0, OUT_ready=1.
- Full beat: IN_ready=1; stream words 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> the cycle after the 4th, OUT_valid=1, OUT_data=0x00000044_00000033_00000022_00000011, OUT_count=4, OUT_last=0.
- Partial flush: words 0xA,0xB with IN_last on 0xB -> OUT_data=0x0..0_0000000B_0000000A, OUT_count=2, OUT_last=1.
- Backpressure: beat valid, IN_ready=0 for 5 cycles with IN_valid=1 -> OUT_ready=0, OUT_data/OUT_count stable. Then IN_ready=1 -> the beat retires and 0x55 lands in lane 0, cnt=1.
- Sustained throughput: 16 words back-to-back, IN_ready=1 -> 4 beats on consecutive 4-cycle boundaries, no dropped or duplicated words (scoreboard against the FIFO input stream).
- RATIO=1 build: every accepted word gives a beat the next cycle. With IN_ready=1 and IN_valid=1, OUT_valid stays high every cycle.
